// File: rtl/opll_temporal_mixer_p.sv
// Time-multiplexed OPLL slot mixer: walks the 18-slot schedule, accumulates melody and
// rhythm voices separately and publishes melody, rhythm and combined sums once per frame.
module opll_temporal_mixer_p #(
  parameter int unsigned VALUE_W = 9,
  parameter int unsigned MIX_W   = 14,
  parameter bit          SAT     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clkena,
  input  logic [4:0]         slot,
  input  logic [1:0]         stage,
  input  logic               rhythm,
  input  logic [8:0]         chmask,
  input  logic [4:0]         rhymask,
  output logic [4:0]         maddr,
  input  logic               mdata_sign,
  input  logic [VALUE_W-1:0] mdata_value,
  output logic [MIX_W-1:0]   mix_mel,
  output logic [MIX_W-1:0]   mix_rhy,
  output logic [MIX_W-1:0]   mixout,
  output logic               mix_valid,
  output logic               clip
);

  localparam int unsigned PadW = MIX_W + 1 - VALUE_W;

  typedef enum logic [2:0] {VoiceBd, VoiceSd, VoiceTom, VoiceCym, VoiceHh} voice_e;

  logic [4:0]       r_maddr;
  logic             r_mute;
  logic             r_is_rhy;
  logic [MIX_W-1:0] r_acc_mel;
  logic [MIX_W-1:0] r_acc_rhy;
  logic             r_clip_acc;
  logic [MIX_W-1:0] r_mix_mel;
  logic [MIX_W-1:0] r_mix_rhy;
  logic [MIX_W-1:0] r_mixout;
  logic             r_valid;
  logic             r_clip;

  logic [4:0] w_dec_addr;
  logic       w_dec_act;
  logic       w_dec_rhy;
  logic       w_dec_mute;
  logic [3:0] w_dec_ch;
  voice_e     w_dec_voice;

  // Slot schedule decode: melody channel ch reads operator 2*ch+1.
  always_comb begin
    w_dec_act   = 1'b0;
    w_dec_rhy   = 1'b0;
    w_dec_ch    = '0;
    w_dec_voice = VoiceBd;
    case (slot)
      5'd0, 5'd1, 5'd2: begin w_dec_act = 1'b1; w_dec_ch = 4'(slot); end
      5'd6, 5'd7, 5'd8: begin w_dec_act = 1'b1; w_dec_ch = 4'(slot - 5'd3); end
      5'd3:  begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceSd;  end
      5'd4:  begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceCym; end
      5'd9:  begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceHh;  end
      5'd10: begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceTom; end
      5'd11: begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceBd;  end
      5'd12: begin w_dec_act = 1'b1; w_dec_rhy = rhythm; w_dec_voice = VoiceSd;
                   w_dec_ch = 4'd6; end
      5'd13: begin w_dec_act = 1'b1; w_dec_rhy = rhythm; w_dec_voice = VoiceCym;
                   w_dec_ch = 4'd7; end
      5'd14: begin w_dec_act = 1'b1; w_dec_rhy = rhythm; w_dec_voice = VoiceHh;
                   w_dec_ch = 4'd8; end
      5'd15: begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceTom; end
      5'd16: begin w_dec_act = rhythm; w_dec_rhy = rhythm; w_dec_voice = VoiceBd;  end
      default: w_dec_act = 1'b0;
    endcase
    if (w_dec_rhy) begin
      case (w_dec_voice)
        VoiceBd:  w_dec_addr = 5'd13;
        VoiceSd:  w_dec_addr = 5'd15;
        VoiceTom: w_dec_addr = 5'd16;
        VoiceCym: w_dec_addr = 5'd17;
        default:  w_dec_addr = 5'd14;
      endcase
    end else begin
      w_dec_addr = {w_dec_ch, 1'b1};
    end
    w_dec_mute = !w_dec_act || (w_dec_rhy ? rhymask[w_dec_voice] : chmask[w_dec_ch]);
  end

  function automatic logic ovf(input logic [MIX_W:0] s);
    return s[MIX_W] ^ s[MIX_W-1];
  endfunction

  function automatic logic [MIX_W-1:0] fit(input logic [MIX_W:0] s);
    if (SAT && ovf(s)) begin
      return s[MIX_W] ? {1'b1, {(MIX_W-1){1'b0}}} : {1'b0, {(MIX_W-1){1'b1}}};
    end
    return s[MIX_W-1:0];
  endfunction

  logic [MIX_W:0] w_addend;
  logic [MIX_W:0] w_acc_ext;
  logic [MIX_W:0] w_sum;
  logic [MIX_W:0] w_tot;

  assign w_addend  = {{PadW{1'b0}}, mdata_value};
  assign w_acc_ext = r_is_rhy ? {r_acc_rhy[MIX_W-1], r_acc_rhy}
                              : {r_acc_mel[MIX_W-1], r_acc_mel};
  assign w_sum     = mdata_sign ? (w_acc_ext - w_addend) : (w_acc_ext + w_addend);
  assign w_tot     = {r_acc_mel[MIX_W-1], r_acc_mel} + {r_acc_rhy[MIX_W-1], r_acc_rhy};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_maddr    <= '0;
      r_mute     <= 1'b1;
      r_is_rhy   <= 1'b0;
      r_acc_mel  <= '0;
      r_acc_rhy  <= '0;
      r_clip_acc <= 1'b0;
      r_mix_mel  <= '0;
      r_mix_rhy  <= '0;
      r_mixout   <= '0;
      r_valid    <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      // The strobe lasts one clk even when clkena is low.
      r_valid <= 1'b0;
      if (clkena) begin
        if (stage == 2'd0) begin
          r_mute   <= w_dec_mute;
          r_is_rhy <= w_dec_rhy;
          if (!w_dec_mute) r_maddr <= w_dec_addr;
        end
        if (stage == 2'd2) begin
          if (slot == 5'd17) begin
            r_mix_mel  <= r_acc_mel;
            r_mix_rhy  <= r_acc_rhy;
            r_mixout   <= fit(w_tot);
            r_clip     <= r_clip_acc | ovf(w_tot);
            r_valid    <= 1'b1;
            r_acc_mel  <= '0;
            r_acc_rhy  <= '0;
            r_clip_acc <= 1'b0;
          end else if (!r_mute) begin
            if (r_is_rhy) r_acc_rhy <= fit(w_sum);
            else          r_acc_mel <= fit(w_sum);
            if (ovf(w_sum)) r_clip_acc <= 1'b1;
          end
        end
      end
    end
  end

  assign maddr     = r_maddr;
  assign mix_mel   = r_mix_mel;
  assign mix_rhy   = r_mix_rhy;
  assign mixout    = r_mixout;
  assign mix_valid = r_valid;
  assign clip      = r_clip;

endmodule

// File: tb/tb_opll_temporal_mixer_p.sv
// Bench for opll_temporal_mixer_p: three parameter sets share one stimulus; a frame-level
// model predicts every published frame and a few literal values pin the model.
module tb_opll_temporal_mixer_p;

  logic       clk = 1'b0;
  logic       reset;
  logic       clkena;
  logic [4:0] slot;
  logic [1:0] stage;
  logic       rhythm;
  logic [8:0] chmask;
  logic [4:0] rhymask;
  logic       mdata_sign;
  logic [8:0] mdata_value;

  logic [4:0]  a_maddr, b_maddr, c_maddr;
  logic [13:0] a_mel, a_rhy, a_mix;
  logic [11:0] b_mel, b_rhy, b_mix, c_mel, c_rhy, c_mix;
  logic        a_valid, b_valid, c_valid, a_clip, b_clip, c_clip;

  always #5 clk = ~clk;

  opll_temporal_mixer_p u_a (
    .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage), .rhythm(rhythm),
    .chmask(chmask), .rhymask(rhymask), .maddr(a_maddr), .mdata_sign(mdata_sign),
    .mdata_value(mdata_value), .mix_mel(a_mel), .mix_rhy(a_rhy), .mixout(a_mix),
    .mix_valid(a_valid), .clip(a_clip)
  );

  opll_temporal_mixer_p #(.VALUE_W(9), .MIX_W(12), .SAT(1'b1)) u_b (
    .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage), .rhythm(rhythm),
    .chmask(chmask), .rhymask(rhymask), .maddr(b_maddr), .mdata_sign(mdata_sign),
    .mdata_value(mdata_value), .mix_mel(b_mel), .mix_rhy(b_rhy), .mixout(b_mix),
    .mix_valid(b_valid), .clip(b_clip)
  );

  opll_temporal_mixer_p #(.VALUE_W(9), .MIX_W(12), .SAT(1'b0)) u_c (
    .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage), .rhythm(rhythm),
    .chmask(chmask), .rhymask(rhymask), .maddr(c_maddr), .mdata_sign(mdata_sign),
    .mdata_value(mdata_value), .mix_mel(c_mel), .mix_rhy(c_rhy), .mixout(c_mix),
    .mix_valid(c_valid), .clip(c_clip)
  );

  typedef struct packed {int mel; int rhy; int mix; logic clp;} exp_t;
  exp_t q_a[$], q_b[$], q_c[$];

  int tests = 0, fails = 0;
  int n_valid_a = 0, frames_exp = 0, last_addr = 0;
  int cap_a_mel, cap_a_rhy, cap_a_mix, cap_a_clip, cap_b_mel, cap_b_clip, cap_c_mel, cap_c_clip;
  logic [13:0] cap_a_mix_raw;

  // Schedule tables: operator address per slot (-1 = idle) and rhythm voice (0=BD..4=HH).
  int mel_tab [18] = '{1, 3, 5, -1, -1, -1, 7, 9, 11, -1, -1, -1, 13, 15, 17, -1, -1, -1};
  int rhy_tab [18] = '{1, 3, 5, 15, 17, -1, 7, 9, 11, 14, 16, 13, 15, 17, 14, 16, 13, -1};
  int rv_tab  [18] = '{-1, -1, -1, 1, 3, -1, -1, -1, -1, 4, 2, 0, 1, 3, 4, 2, 0, -1};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void slot_info(input int s, output int addr, output bit act,
                                    output bit isr, output bit msk);
    addr = rhythm ? rhy_tab[s] : mel_tab[s];
    isr  = rhythm && rv_tab[s] >= 0;
    act  = addr >= 0;
    msk  = 1'b0;
    if (act) msk = isr ? rhymask[rv_tab[s]] : chmask[(addr - 1) / 2];
  endfunction

  function automatic int fitw(input int x, input int w, input bit sat, output bit ov);
    int mx = (1 << (w - 1)) - 1;
    int mn = -(1 << (w - 1));
    int y;
    ov = (x > mx) || (x < mn);
    if (!ov) return x;
    if (sat) return (x > mx) ? mx : mn;
    y = x & ((1 << w) - 1);
    if (y > mx) y -= (1 << w);
    return y;
  endfunction

  // Expected published frame when slots first..16 are processed with the current inputs.
  function automatic exp_t model(input int first, input int w, input bit sat);
    exp_t r;
    int mel = 0, rhy = 0, v, addr;
    bit clp = 1'b0, ov, act, isr, msk;
    v = mdata_sign ? -int'(mdata_value) : int'(mdata_value);
    for (int s = first; s < 17; s++) begin
      slot_info(s, addr, act, isr, msk);
      if (act && !msk) begin
        if (isr) rhy = fitw(rhy + v, w, sat, ov);
        else     mel = fitw(mel + v, w, sat, ov);
        clp |= ov;
      end
    end
    r.mel = mel;
    r.rhy = rhy;
    r.mix = fitw(mel + rhy, w, sat, ov);
    r.clp = clp | ov;
    return r;
  endfunction

  task automatic cmp_frame(input string tag, input exp_t e, input int mel, input int rhy,
                           input int mix, input int clp);
    chk({tag, "_mix_mel"}, mel, e.mel);
    chk({tag, "_mix_rhy"}, rhy, e.rhy);
    chk({tag, "_mixout"}, mix, e.mix);
    chk({tag, "_clip"}, clp, int'(e.clp));
  endtask

  always @(negedge clk) begin
    if (a_valid) begin
      n_valid_a++;
      if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
      else cmp_frame("a", q_a.pop_front(), $signed(a_mel), $signed(a_rhy), $signed(a_mix),
                     a_clip);
      cap_a_mel = $signed(a_mel); cap_a_rhy = $signed(a_rhy); cap_a_mix = $signed(a_mix);
      cap_a_mix_raw = a_mix; cap_a_clip = a_clip;
    end
    if (b_valid) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
      else cmp_frame("b", q_b.pop_front(), $signed(b_mel), $signed(b_rhy), $signed(b_mix),
                     b_clip);
      cap_b_mel = $signed(b_mel); cap_b_clip = b_clip;
    end
    if (c_valid) begin
      if (q_c.size() == 0) chk("c_unexpected_valid", 1, 0);
      else cmp_frame("c", q_c.pop_front(), $signed(c_mel), $signed(c_rhy), $signed(c_mix),
                     c_clip);
      cap_c_mel = $signed(c_mel); cap_c_clip = c_clip;
    end
  end

  task automatic do_hold(input int n);
    int m = a_maddr, mel = a_mel, mix = a_mix;
    for (int i = 0; i < n; i++) begin
      clkena = 1'b0;
      stage  = 2'd2;
      @(posedge clk); #1;
      chk("hold_maddr", a_maddr, m);
      chk("hold_mix_mel", a_mel, mel);
      chk("hold_mixout", a_mix, mix);
      chk("hold_valid_low", a_valid, 0);
    end
  endtask

  task automatic run_slot(input int s, input int hold_at, input int hold_n);
    int addr;
    bit act, isr, msk;
    slot_info(s, addr, act, isr, msk);
    for (int st = 0; st < 4; st++) begin
      slot = 5'(s); stage = 2'(st); clkena = 1'b1;
      @(posedge clk); #1;
      if (st == 0) begin
        if (act && !msk) begin
          chk("maddr", a_maddr, addr);
          last_addr = addr;
        end else if (!act && last_addr >= 0) begin
          chk("maddr_hold", a_maddr, last_addr);
        end else if (act) begin
          last_addr = -1;
        end
      end
      if (s == 17 && st == 2) chk("valid_pulse", a_valid, 1);
      if (st == hold_at) do_hold(hold_n);
    end
  endtask

  task automatic run_frame(input int first, input int hold_slot, input int hold_at,
                           input int hold_n);
    for (int s = first; s < 18; s++) begin
      if (s == 17) begin
        q_a.push_back(model(first, 14, 1'b1));
        q_b.push_back(model(first, 12, 1'b1));
        q_c.push_back(model(first, 12, 1'b0));
        frames_exp++;
      end
      run_slot(s, (s == hold_slot) ? hold_at : -1, hold_n);
    end
    chk("valid_count", n_valid_a, frames_exp);
  endtask

  task automatic set_in(input bit rm, input int cm, input int rk, input bit sg, input int v);
    rhythm = rm; chmask = 9'(cm); rhymask = 5'(rk); mdata_sign = sg; mdata_value = 9'(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clkena = 1'b0; slot = '0; stage = '0;
    set_in(0, 0, 0, 0, 100);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_maddr", a_maddr, 0);  chk("rst_mix_mel", a_mel, 0);
    chk("rst_mix_rhy", a_rhy, 0);  chk("rst_mixout", a_mix, 0);
    chk("rst_valid", a_valid, 0);  chk("rst_clip", a_clip, 0);
    reset = 1'b0;

    // Melody mode, +100 on every slot.
    run_frame(0, -1, -1, 0);
    run_frame(0, -1, -1, 0);
    chk("lit_mel900", cap_a_mel, 900); chk("lit_rhy0", cap_a_rhy, 0);
    chk("lit_mix900", cap_a_mix, 900); chk("lit_clip0", cap_a_clip, 0);

    // Rhythm mode: each rhythm voice counted twice.
    set_in(1, 0, 0, 0, 100);
    run_frame(0, -1, -1, 0);
    chk("lit_rmel600", cap_a_mel, 600); chk("lit_rrhy1000", cap_a_rhy, 1000);
    chk("lit_rmix1600", cap_a_mix, 1600);
    set_in(1, 'h1C0, 'h01, 0, 100);
    run_frame(0, -1, -1, 0);
    chk("lit_hi_chmask_ignored", cap_a_mel, 600); chk("lit_bd_muted", cap_a_rhy, 800);

    // Negative data, then mute channel 0.
    set_in(0, 0, 0, 1, 100);
    run_frame(0, -1, -1, 0);
    chk("lit_neg_raw", int'(cap_a_mix_raw), 'h3C7C);
    set_in(0, 'h001, 0, 1, 100);
    run_frame(0, -1, -1, 0);
    chk("lit_ch0_muted", cap_a_mix, -800);

    // Overflow: 9 x 511 exceeds a 12-bit accumulator.
    set_in(0, 0, 0, 0, 511);
    run_frame(0, -1, -1, 0);
    chk("lit_sat_mel", cap_b_mel, 2047); chk("lit_sat_clip", cap_b_clip, 1);
    chk("lit_wrap_mel", cap_c_mel, 503); chk("lit_wrap_clip", cap_c_clip, 1);
    chk("lit_w14_noclip", cap_a_clip, 0);
    set_in(1, 0, 'h04, 1, 511);
    run_frame(0, -1, -1, 0);

    // Reset before slot 8: partial frame, then a clean full frame.
    set_in(0, 0, 0, 0, 100);
    for (int s = 0; s < 8; s++) run_slot(s, -1, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_maddr", a_maddr, 0);   chk("mid_rst_mix_mel", a_mel, 0);
    chk("mid_rst_mixout", a_mix, 0);    chk("mid_rst_clip", a_clip, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_addr = 0;
    run_frame(8, -1, -1, 0);
    run_frame(0, -1, -1, 0);
    chk("lit_after_reset", cap_a_mel, 900);

    // Clock-enable gaps mid-frame and right after the publish.
    run_frame(0, 8, 0, 5);
    chk("lit_hold_sum", cap_a_mix, 900);
    run_frame(0, 17, 2, 2);
    chk("lit_hold_after_pub", cap_a_mix, 900);

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    chk("queue_c_empty", q_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
